fp_add_issue_ctrl: RTL and testbench
====================================

Name: fp_add_issue_ctrl

Overview:
Upstream issue and result-collection stage for the fixed-latency single-precision adder (fp_add).
- Accepts add requests over a valid/ready handshake and registers the operands and rounding mode onto the adder inputs.
- Tracks in-flight operations through a valid/tag shift pipeline matched to the adder latency.
- Captures each result and its exception flags into an output FIFO drained over valid/ready.
- Credit gating ensures a result never arrives without a free FIFO slot; the adder itself has no stall.

Parameters:
W, 32, operand/result width
LAT, 2, clock edges from adder input change to valid adder output
DEPTH, 8, result FIFO entries (power of two, >= LAT+2)
TAG_W, 4, width of the opaque request tag

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  request accepted when valid&ready at posedge
req_a  input  W  operand 1
req_b  input  W  operand 2
req_rm  input  3  rounding mode (RNe/RNa/RZ/RU/RD encodings)
req_tag  input  TAG_W  tag returned with the result
add_in1  output  W  to adder in1 (registered)
add_in2  output  W  to adder in2 (registered)
add_round_m  output  3  to adder round_m (registered)
add_out  input  W  adder result
add_ov, add_un, add_inv, add_inexact  input  1 each  adder flags
rsp_valid  output  1  result available
rsp_ready  input  1  consumer takes result at posedge
rsp_data  output  W  result
rsp_flags  output  4  {inv,ov,un,inexact}
rsp_tag  output  TAG_W  tag of the request

Behaviour:
- Reset (rst low, async):
  - add_in1, add_in2, add_round_m = 0.
  - Issue valid and all pipe valids = 0.
  - FIFO pointers and count = 0; rsp_valid = 0.
  - rsp_data, rsp_flags, rsp_tag read as 0 when the FIFO is empty.
  - A reset mid-operation discards every in-flight and queued result. No partial result is delivered afterwards.
- Occupancy = FIFO count + popcount(issue valid, pipe valids[LAT-1:0]).
- req_ready = (occupancy < DEPTH). It is computed from registers only, with no combinational path from rsp_ready or req_valid.
- Accept (req_valid & req_ready at posedge):
  - add_in1/add_in2/add_round_m <= req_a/req_b/req_rm.
  - issue_v <= 1; issue_tag <= req_tag.
  - Otherwise issue_v <= 0. The operand registers hold their last value; the adder keeps computing on it, but the result is untagged and ignored.
- Pipe: vpipe[0] <= issue_v, vpipe[k] <= vpipe[k-1]; tag pipe runs in parallel. vpipe[LAT-1] high means add_out and the flags belong to that tag in the current cycle.
- Capture: while vpipe[LAT-1] is high, write {add_out, flags, tag} into the FIFO at that edge.
  - The write never finds the FIFO full; credit guarantees it.
  - Overflow is an assertion error.
- Latency: accept edge at cycle 0 gives rsp_valid high from cycle LAT+2 (4 cycles at default).
- Throughput: one op per cycle sustained while rsp_ready=1 and DEPTH >= LAT+3.
- Ordering is strictly in order; tags are opaque and may repeat.
- FIFO behaviour:
  - rsp_* is driven from the read pointer.
  - Pop on rsp_valid & rsp_ready.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo DEPTH.
  - Pop when empty is ignored.
- rsp_valid, once high, stays high with rsp_* stable until popped.

Optional Feature:
FADD_STICKY_FLAGS_EN
- Defined:
  - Adds input flags_clr (1) and output fflags (4).
  - fflags <= (fflags | rsp_flags) at each pop.
  - flags_clr takes priority: fflags <= 0, or just the popped flags if a pop occurs in the same cycle.
  - Reset value 0.
- Undefined: neither port exists and no flag state is kept.

Decomposition:
- Shared package (fp_pkg, alongside special_characters definitions):
  - rounding-mode encodings
  - flag-bit index constants (FLG_INV=3, FLG_OV=2, FLG_UN=1, FLG_NX=0)
  - a result-entry struct {data, flags, tag}
- One natural sub-module: fp_result_fifo, a synchronous FIFO parameterised by DEPTH and entry width, with count output.

Test Plan:
- Bench: fp_add connected to the add_* ports; rsp_ready=1.
- Accept 0x3F800000 + 0x40000000, RNe, tag 3 → rsp_valid rises 4 cycles later; rsp_data=0x40400000, flags=0000, tag=3.
- Back-to-back 6 requests, tags 0..5, rsp_ready=1 → one response per cycle, tags 0..5 in order, req_ready never drops.
- rsp_ready=0, stream requests → req_ready falls after exactly DEPTH=8 accepts. Release rsp_ready → 8 results arrive in order with none lost; req_ready reasserts.
- +inf (0x7F800000) + -inf (0xFF800000) → rsp_data=FP_NANQ, flags=1000. With FADD_STICKY_FLAGS_EN, fflags=1000 until flags_clr.
- 0x7F7FFFFF + 0x7F7FFFFF, RNe → ov flag set in rsp_flags. Pulse flags_clr together with the pop → fflags equals that pop's flags only.
- Accept 3 requests, assert rst low for 1 cycle mid-flight → rsp_valid stays 0 afterwards, req_ready=1, occupancy 0.

Source files
------------

// File: rtl/fp_pkg.sv
// fp_pkg: shared FP constants, rounding modes, flag layout and result entry.
// Used by the fp_add issue/collect slice.
package fp_pkg;

    localparam int FP_W     = 32;
    localparam int FP_TAG_W = 4;

    localparam logic [2:0] RM_RNE = 3'b000;
    localparam logic [2:0] RM_RZ  = 3'b001;
    localparam logic [2:0] RM_RD  = 3'b010;
    localparam logic [2:0] RM_RU  = 3'b011;
    localparam logic [2:0] RM_RNA = 3'b100;

    localparam logic [31:0] FP_PZERO = 32'h0000_0000;
    localparam logic [31:0] FP_NZERO = 32'h8000_0000;
    localparam logic [31:0] FP_PINF  = 32'h7F80_0000;
    localparam logic [31:0] FP_NINF  = 32'hFF80_0000;
    localparam logic [31:0] FP_NANQ  = 32'h7FC0_0000;

    localparam int FLG_INV = 3;
    localparam int FLG_OV  = 2;
    localparam int FLG_UN  = 1;
    localparam int FLG_NX  = 0;

    typedef struct packed {
        logic [FP_W-1:0]     data;
        logic [3:0]          flags;
        logic [FP_TAG_W-1:0] tag;
    } res_entry_t;

    function automatic logic [3:0] pack_flags(input logic inv, input logic ov,
                                              input logic un, input logic nx);
        logic [3:0] f;
        f          = '0;
        f[FLG_INV] = inv;
        f[FLG_OV]  = ov;
        f[FLG_UN]  = un;
        f[FLG_NX]  = nx;
        return f;
    endfunction

endpackage

// File: rtl/fp_result_fifo.sv
// fp_result_fifo: synchronous FIFO with occupancy count.
// Empty reads return zero; pops on empty are dropped.
module fp_result_fifo
    import fp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int EW    = 40
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [EW-1:0]          wdata_i,
    input  logic                   pop_i,
    output logic [EW-1:0]          rdata_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [EW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          empty;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign do_pop  = pop_i & ~empty;
    assign count_o = count_q;
    assign rdata_o = empty ? '0 : mem_q[rd_ptr_q];

    // pointer and count next state; pointers wrap naturally at DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop) rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push_i, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // pointer and count state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // storage; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        push_i |-> (count_q != (AW+1)'(DEPTH)));

endmodule

// File: rtl/fp_add_issue_ctrl.sv
// fp_add_issue_ctrl: registers requests onto fp_add, tracks them, queues results.
// Build option FADD_STICKY_FLAGS_EN adds flags_clr / fflags accumulation.
module fp_add_issue_ctrl
    import fp_pkg::*;
#(
    parameter int W     = 32,
    parameter int LAT   = 2,
    parameter int DEPTH = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [W-1:0]     req_a,
    input  logic [W-1:0]     req_b,
    input  logic [2:0]       req_rm,
    input  logic [TAG_W-1:0] req_tag,
    output logic [W-1:0]     add_in1,
    output logic [W-1:0]     add_in2,
    output logic [2:0]       add_round_m,
    input  logic [W-1:0]     add_out,
    input  logic             add_ov,
    input  logic             add_un,
    input  logic             add_inv,
    input  logic             add_inexact,
`ifdef FADD_STICKY_FLAGS_EN
    input  logic             flags_clr,
    output logic [3:0]       fflags,
`endif
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [W-1:0]     rsp_data,
    output logic [3:0]       rsp_flags,
    output logic [TAG_W-1:0] rsp_tag
);
    localparam int EW = W + 4 + TAG_W;
    localparam int AW = $clog2(DEPTH);
    localparam int OW = $clog2(DEPTH + LAT + 2) + 1;

    logic [W-1:0]     in1_q, in1_d;
    logic [W-1:0]     in2_q, in2_d;
    logic [2:0]       rm_q, rm_d;
    logic             iv_q, iv_d;
    logic [TAG_W-1:0] itag_q, itag_d;
    logic [LAT-1:0]   vpipe_q;
    logic [TAG_W-1:0] tpipe_q [LAT];
    logic [AW:0]      fifo_cnt;
    logic [EW-1:0]    fifo_wdata;
    logic [EW-1:0]    fifo_rdata;
    logic [OW-1:0]    occ;
    logic             accept;
    logic             rsp_pop;

    assign accept      = req_valid & req_ready;
    assign rsp_pop     = rsp_valid & rsp_ready;
    assign add_in1     = in1_q;
    assign add_in2     = in2_q;
    assign add_round_m = rm_q;

    // credit: every issued-but-unpopped op owns a FIFO slot
    always_comb begin
        occ = OW'(fifo_cnt) + OW'(iv_q);
        for (int k = 0; k < LAT; k++) occ = occ + OW'(vpipe_q[k]);
    end

    assign req_ready = (occ < OW'(DEPTH));

    // issue stage next state; operands hold when nothing is accepted
    always_comb begin
        in1_d  = in1_q;
        in2_d  = in2_q;
        rm_d   = rm_q;
        itag_d = itag_q;
        iv_d   = 1'b0;
        if (accept) begin
            in1_d  = req_a;
            in2_d  = req_b;
            rm_d   = req_rm;
            itag_d = req_tag;
            iv_d   = 1'b1;
        end
    end

    // issue registers feeding the adder
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            in1_q  <= '0;
            in2_q  <= '0;
            rm_q   <= '0;
            iv_q   <= 1'b0;
            itag_q <= '0;
        end else begin
            in1_q  <= in1_d;
            in2_q  <= in2_d;
            rm_q   <= rm_d;
            iv_q   <= iv_d;
            itag_q <= itag_d;
        end
    end

    // valid/tag shadow pipe aligned with the adder latency
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vpipe_q <= '0;
            for (int k = 0; k < LAT; k++) tpipe_q[k] <= '0;
        end else begin
            vpipe_q[0] <= iv_q;
            tpipe_q[0] <= itag_q;
            for (int k = 1; k < LAT; k++) begin
                vpipe_q[k] <= vpipe_q[k-1];
                tpipe_q[k] <= tpipe_q[k-1];
            end
        end
    end

    assign fifo_wdata = {add_out,
                         pack_flags(add_inv, add_ov, add_un, add_inexact),
                         tpipe_q[LAT-1]};

    fp_result_fifo #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (vpipe_q[LAT-1]),
        .wdata_i (fifo_wdata),
        .pop_i   (rsp_pop),
        .rdata_o (fifo_rdata),
        .count_o (fifo_cnt)
    );

    assign rsp_valid = (fifo_cnt != '0);
    assign {rsp_data, rsp_flags, rsp_tag} = fifo_rdata;

`ifdef FADD_STICKY_FLAGS_EN
    logic [3:0] fflags_q, fflags_d;

    // clear wins over accumulate but keeps a same-cycle pop's flags
    always_comb begin
        fflags_d = fflags_q;
        if (flags_clr)    fflags_d = rsp_pop ? rsp_flags : 4'b0000;
        else if (rsp_pop) fflags_d = fflags_q | rsp_flags;
    end

    // sticky flag register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) fflags_q <= '0;
        else      fflags_q <= fflags_d;
    end

    assign fflags = fflags_q;
`endif

endmodule

// File: tb/tb_fp_add_issue_ctrl.sv
// tb_fp_add_issue_ctrl: directed scoreboard bench with a 2-stage adder stand-in.
// Define FADD_STICKY_FLAGS_EN to also exercise fflags / flags_clr.
`timescale 1ns/1ps
module tb_fp_add_issue_ctrl;
    import fp_pkg::*;

    localparam int W     = 32;
    localparam int LAT   = 2;
    localparam int DEPTH = 8;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [W-1:0]     req_a = '0;
    logic [W-1:0]     req_b = '0;
    logic [2:0]       req_rm = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic [W-1:0]     add_in1, add_in2;
    logic [2:0]       add_round_m;
    logic [W-1:0]     add_out;
    logic             add_ov, add_un, add_inv, add_inexact;
    logic             rsp_valid;
    logic             rsp_ready = 1'b1;
    logic [W-1:0]     rsp_data;
    logic [3:0]       rsp_flags;
    logic [TAG_W-1:0] rsp_tag;
`ifdef FADD_STICKY_FLAGS_EN
    logic             flags_clr = 1'b0;
    logic [3:0]       fflags;
`endif

    always #5 clk = ~clk;

    fp_add_issue_ctrl #(
        .W(W), .LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_rm(req_rm), .req_tag(req_tag),
        .add_in1(add_in1), .add_in2(add_in2), .add_round_m(add_round_m),
        .add_out(add_out), .add_ov(add_ov), .add_un(add_un),
        .add_inv(add_inv), .add_inexact(add_inexact),
`ifdef FADD_STICKY_FLAGS_EN
        .flags_clr(flags_clr), .fflags(fflags),
`endif
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_flags(rsp_flags), .rsp_tag(rsp_tag)
    );

    // adder stand-in: lookup of known sums, result {r, ov, un, inv, nx}
    function automatic logic [35:0] add_model(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input logic [2:0] rm);
        logic [31:0] r;
        logic [3:0]  f;
        r = 32'hDEADBEEF;
        f = 4'b0000;
        if (rm == RM_RNE) begin
            case ({a, b})
                {32'h3F800000, 32'h40000000}: r = 32'h40400000;
                {32'h40400000, 32'h3F800000}: r = 32'h40800000;
                {32'h3F000000, 32'h3F000000}: r = 32'h3F800000;
                {32'h3FC00000, 32'h3FC00000}: r = 32'h40400000;
                {32'h40800000, 32'h40800000}: r = 32'h41000000;
                {32'hBF800000, 32'h3F800000}: r = 32'h00000000;
                {32'h40000000, 32'h40000000}: r = 32'h40800000;
                {32'h3F800000, 32'h3F800000}: r = 32'h40000000;
                {32'h7F800000, 32'hFF800000}: begin
                    r = 32'h7FC00000; f = 4'b0010;
                end
                {32'h7F7FFFFF, 32'h7F7FFFFF}: begin
                    r = 32'h7F800000; f = 4'b1001;
                end
                default: ;
            endcase
        end
        return {r, f};
    endfunction

    logic [35:0] s1 = '0;
    logic [35:0] s2 = '0;

    always_ff @(posedge clk) begin
        s1 <= add_model(add_in1, add_in2, add_round_m);
        s2 <= s1;
    end

    assign add_out     = s2[35:4];
    assign add_ov      = s2[3];
    assign add_un      = s2[2];
    assign add_inv     = s2[1];
    assign add_inexact = s2[0];

    // directed vectors: a + b = r under RNe, all exact
    logic [31:0] va [8] = '{32'h3F800000, 32'h40400000, 32'h3F000000, 32'h3FC00000,
                            32'h40800000, 32'hBF800000, 32'h40000000, 32'h3F800000};
    logic [31:0] vb [8] = '{32'h40000000, 32'h3F800000, 32'h3F000000, 32'h3FC00000,
                            32'h40800000, 32'h3F800000, 32'h40000000, 32'h3F800000};
    logic [31:0] vr [8] = '{32'h40400000, 32'h40800000, 32'h3F800000, 32'h40400000,
                            32'h41000000, 32'h00000000, 32'h40800000, 32'h40000000};

    int         npass = 0;
    int         ntot  = 0;
    int         stalls = 0;
    res_entry_t sb [$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // monitor: pop expected entry on every handshake; check hold while stalled
    logic        hold_v = 1'b0;
    logic [39:0] hold   = '0;
    res_entry_t  got_e;

    always @(negedge clk) begin
        if (!rst) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v)
                chk("rsp_hold", {rsp_valid, rsp_data, rsp_flags, rsp_tag}, {1'b1, hold});
            if (rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    ntot++;
                    $display("FAIL rsp_unexpected: got tag %0h data %0h expected none",
                             rsp_tag, rsp_data);
                end else begin
                    got_e = sb.pop_front();
                    chk("rsp_data", rsp_data, got_e.data);
                    chk("rsp_flags", rsp_flags, got_e.flags);
                    chk("rsp_tag", rsp_tag, got_e.tag);
                end
            end
            hold_v = rsp_valid && !rsp_ready;
            hold   = {rsp_data, rsp_flags, rsp_tag};
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] rm, input logic [3:0] tag,
                        input logic [31:0] ed, input logic [3:0] ef);
        int         n;
        logic       acc;
        res_entry_t e;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        req_rm    = rm;
        req_tag   = tag;
        n   = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            if (acc) begin
                e.data  = ed;
                e.flags = ef;
                e.tag   = tag;
                sb.push_back(e);
            end else begin
                n++;
                stalls++;
            end
        end
        #1;
        req_valid = 1'b0;
        if (!acc) begin
            ntot++;
            $display("FAIL send_timeout: got %0d stalled cycles expected acceptance", n);
        end
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(output int k);
        logic seen;
        k    = 0;
        seen = 1'b0;
        while (!seen && k < 20) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                k++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_req_ready", req_ready, 1'b1);
        chk("rst_add_in", {add_in1, add_in2, add_round_m}, '0);
        chk("rst_rsp_fields", {rsp_data, rsp_flags, rsp_tag}, '0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(2);

        // single op, latency: accept cycle is cycle 0, result seen in cycle 4,
        // i.e. after the third edge following the accept edge
        send(32'h3F800000, 32'h40000000, RM_RNE, 4'd3, 32'h40400000, 4'b0000);
        wait_rsp(k);
        chk("latency_edges", k, LAT + 1);
        idle(4);

        // six back-to-back ops, no stall expected
        stalls = 0;
        for (int i = 0; i < 6; i++) send(va[i], vb[i], RM_RNE, 4'(i), vr[i], 4'b0000);
        chk("b2b_stalls", stalls, 0);
        idle(6);
        chk("b2b_drained", sb.size(), 0);

        // backpressure: exactly DEPTH accepts, then ready drops
        rsp_ready = 1'b0;
        stalls = 0;
        for (int i = 0; i < 8; i++) send(va[i], vb[i], RM_RNE, 4'(8 + i), vr[i], 4'b0000);
        chk("bp_stalls", stalls, 0);
        @(negedge clk);
        chk("bp_ready_low", req_ready, 1'b0);
        req_valid = 1'b1;
        req_a = va[7];
        req_b = vb[7];
        req_tag = 4'd0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bp_still_low", {req_ready, rsp_valid}, 2'b01);
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        send(va[7], vb[7], RM_RNE, 4'd0, vr[7], 4'b0000);
        idle(12);
        chk("bp_drained", sb.size(), 0);
        @(negedge clk);
        chk("bp_ready_back", req_ready, 1'b1);
        @(posedge clk);
        #1;

        // invalid: inf + -inf
        send(FP_PINF, FP_NINF, RM_RNE, 4'd5, FP_NANQ, 4'b1000);
        idle(5);
`ifdef FADD_STICKY_FLAGS_EN
        chk("fflags_inv", fflags, 4'b1000);
`endif

        // overflow, held under backpressure, then popped with flags_clr
        rsp_ready = 1'b0;
        send(32'h7F7FFFFF, 32'h7F7FFFFF, RM_RNE, 4'd6, FP_PINF, 4'b0101);
        wait_rsp(k);
        chk("ovf_latency", k, LAT + 1);
        @(posedge clk);
        #1;
`ifdef FADD_STICKY_FLAGS_EN
        chk("fflags_kept", fflags, 4'b1000);
        flags_clr = 1'b1;
`endif
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
`ifdef FADD_STICKY_FLAGS_EN
        flags_clr = 1'b0;
        chk("fflags_clr_pop", fflags, 4'b0101);
`endif
        idle(3);
        chk("ovf_drained", sb.size(), 0);

        // reset with three ops in flight
        for (int i = 0; i < 3; i++) send(va[i], vb[i], RM_RNE, 4'(1 + i), vr[i], 4'b0000);
        rst = 1'b0;
        sb.delete();
        @(negedge clk);
        chk("midrst_rsp_valid", rsp_valid, 1'b0);
        chk("midrst_add_in1", add_in1, '0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(8);
        @(negedge clk);
        chk("postrst_idle", {rsp_valid, req_ready}, 2'b01);
`ifdef FADD_STICKY_FLAGS_EN
        chk("postrst_fflags", fflags, 4'b0000);
`endif
        @(posedge clk);
        #1;

        // recovery after reset
        send(32'h3F800000, 32'h3F800000, RM_RNE, 4'd9, 32'h40000000, 4'b0000);
        idle(6);
        chk("final_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
